ga_fitness_eval: RTL
====================

# ga_fitness_eval

Parametrised, multi-lane knapsack fitness evaluator for the genetic-algorithm engine. It accepts one chromosome per valid/ready handshake and accumulates item value and weight LANES items per cycle. It then applies a selectable capacity-constraint mode and returns fitness, weight, feasibility and tag through a valid/ready output. It also keeps a running best-so-far record. It sits between the population memory and the tournament-selection logic, replacing single-item, hard-constraint fitness evaluation.

## Interface
- N_ITEMS, 128: chromosome length / item count; must be a multiple of LANES.
- LANES, 4: items summed per cycle.
- VALUE_W, 8: per-item value width.
- WEIGHT_W, 8: per-item weight width.
- CAP_W, 16: capacity width.
- FIT_W, 16: fitness / weight output width; results saturate to 2^FIT_W-1.
- TAG_W, 8: individual-index tag width.
- PEN_SHIFT, 1: penalty = excess << PEN_SHIFT in penalty mode.

Ports:
- clk  in  1  clock.
- rst  in  1  reset, synchronous, active-low.
- in_valid  in  1  chromosome offered.
- in_ready  out  1  high only in IDLE with rst high.
- in_chrom  in  N_ITEMS  bit i selects item i.
- in_tag  in  TAG_W  individual index.
- mode  in  2  0 hard-zero, 1 linear penalty, 2 unconstrained, 3 treated as 0.
- capacity  in  CAP_W  weight limit.
- item_values  in  N_ITEMS*VALUE_W  item i at [i*VALUE_W +: VALUE_W].
- item_weights  in  N_ITEMS*WEIGHT_W  same packing.
- clear_best  in  1  one-cycle pulse, clears best record.
- out_valid  out  1  result available.
- out_ready  in  1  consumer accepts.
- out_fitness  out  FIT_W  constrained fitness.
- out_weight  out  FIT_W  total selected weight, saturated.
- out_feasible  out  1  weight <= capacity.
- out_tag  out  TAG_W  tag captured with the chromosome.
- best_fitness  out  FIT_W  best fitness since reset or clear.
- best_tag  out  TAG_W  tag of that result.
- best_valid  out  1  best record holds an entry.

## Operation
- States: IDLE, ACCUM, FINAL, OUT.
- IDLE: on in_valid&&in_ready, capture in_chrom, in_tag, mode and capacity, clear accumulators and the chunk counter, and go to ACCUM.
- ACCUM: each cycle add the selected values and weights of chunk k (items k*LANES .. k*LANES+LANES-1). After chunk N_ITEMS/LANES-1, go to FINAL.
- Accumulator width: ACC_W = max(VALUE_W, WEIGHT_W) + clog2(N_ITEMS+1). Accumulation never overflows.
- FINAL: compute the result, register the outputs, set out_valid, go to OUT.
  - excess = weight - capacity when weight > capacity, else 0.
  - Mode 0: fitness = feasible ? value : 0.
  - Mode 1: fitness = max(value - (excess << PEN_SHIFT), 0).
  - Mode 2: fitness = value.
  - All results saturate to FIT_W bits.
- Best tracker, updated in FINAL: replace the record when (out_feasible || mode==2) && (!best_valid || fitness > best_fitness). Ties keep the earlier entry.
- OUT: outputs are held stable while out_valid && !out_ready. On out_valid&&out_ready, return to IDLE.
- clear_best sets best_valid=0 and best_fitness=0 and best_tag=0 in any state. If it coincides with a FINAL update, the new result is written as the first entry.
- item_values, item_weights must stay stable from acceptance until FINAL. They are not captured.

## Timing
- Reset (rst=0 at a clk edge): state IDLE, all outputs 0 (including in_ready), and the accumulators and best record are cleared.
- Reset mid-operation aborts the evaluation. No out_valid is produced.
- Latency: out_valid is high after N_ITEMS/LANES+1 edges following the accepting edge (33 at defaults).
- Throughput: one chromosome every N_ITEMS/LANES+3 cycles with out_ready held high.
- in_ready is 0 from acceptance until the cycle after the output handshake.
- The best_* outputs change on the same edge that sets out_valid.

## Structure
- Shared package ga_pkg holds:
  - the mode encodings;
  - the state enum;
  - a clog2-based ACC_W helper.
- Sub-module ga_chunk_sum: a combinational LANES-wide masked adder for the value and weight of one chunk, instantiated once.

## Test plan
Bench config N_ITEMS=8, LANES=2, values 10..17, weights all 5, capacity 20, PEN_SHIFT=1.
- Chrom 0x0F, tag 3, mode 0 -> after 5 cycles out_fitness=46, out_weight=20, out_feasible=1, out_tag=3.
- Chrom 0x1F, run in each mode:
  - mode 0 -> fitness 0, weight 25, feasible 0;
  - mode 1 -> 50;
  - mode 2 -> 60.
- Penalty floor: capacity 0, chrom 0x01, mode 1 -> fitness 0. Chrom 0xFF, capacity 20, mode 1 -> 108-40=68.
- Backpressure: hold out_ready=0 for 10 cycles -> outputs stable and in_ready=0 throughout. Release -> one handshake, then in_ready=1 on the next cycle.
- Best tracker: mode 0 sequence tag3 (46), tag5 (infeasible), tag7 (0x0F again, 46) -> best 46, tag 3.
  - Then clear_best -> best_valid=0.
  - Then mode 2 with 0x1F, tag 9 -> best 60, tag 9.
- Reset asserted during ACCUM -> all outputs 0 and no out_valid. The next evaluation is correct.

Source files
------------

// File: rtl/ga_pkg.sv
// Shared encodings and sizing helpers for the GA fitness evaluator.
package ga_pkg;

  typedef enum logic [1:0] {
    MODE_HARD     = 2'd0,
    MODE_PENALTY  = 2'd1,
    MODE_FREE     = 2'd2,
    MODE_HARD_ALT = 2'd3
  } mode_e;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_ACCUM,
    ST_FINAL,
    ST_OUT
  } state_e;

  function automatic int unsigned acc_width(input int unsigned value_w,
                                            input int unsigned weight_w,
                                            input int unsigned n_items);
    return ((value_w > weight_w) ? value_w : weight_w) + $clog2(n_items + 1);
  endfunction

endpackage

// File: rtl/ga_chunk_sum.sv
// Combinational masked adder: sums value and weight of the selected items in one chunk.
module ga_chunk_sum #(
  parameter int unsigned LANES    = 4,
  parameter int unsigned VALUE_W  = 8,
  parameter int unsigned WEIGHT_W = 8,
  parameter int unsigned VSUM_W   = VALUE_W + $clog2(LANES + 1),
  parameter int unsigned WSUM_W   = WEIGHT_W + $clog2(LANES + 1)
) (
  input  logic [LANES-1:0]          sel,
  input  logic [LANES*VALUE_W-1:0]  vals,
  input  logic [LANES*WEIGHT_W-1:0] wts,
  output logic [VSUM_W-1:0]         val_sum,
  output logic [WSUM_W-1:0]         wt_sum
);

  always_comb begin
    val_sum = '0;
    wt_sum  = '0;
    for (int unsigned i = 0; i < LANES; i++) begin
      if (sel[i]) begin
        val_sum = val_sum + VSUM_W'(vals[i*VALUE_W +: VALUE_W]);
        wt_sum  = wt_sum + WSUM_W'(wts[i*WEIGHT_W +: WEIGHT_W]);
      end
    end
  end

endmodule

// File: rtl/ga_fitness_eval.sv
// Multi-lane knapsack fitness evaluator with selectable constraint mode and best-so-far record.
module ga_fitness_eval
  import ga_pkg::*;
#(
  parameter int unsigned N_ITEMS   = 128,
  parameter int unsigned LANES     = 4,
  parameter int unsigned VALUE_W   = 8,
  parameter int unsigned WEIGHT_W  = 8,
  parameter int unsigned CAP_W     = 16,
  parameter int unsigned FIT_W     = 16,
  parameter int unsigned TAG_W     = 8,
  parameter int unsigned PEN_SHIFT = 1
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         in_valid,
  output logic                         in_ready,
  input  logic [N_ITEMS-1:0]           in_chrom,
  input  logic [TAG_W-1:0]             in_tag,
  input  logic [1:0]                   mode,
  input  logic [CAP_W-1:0]             capacity,
  input  logic [N_ITEMS*VALUE_W-1:0]   item_values,
  input  logic [N_ITEMS*WEIGHT_W-1:0]  item_weights,
  input  logic                         clear_best,
  output logic                         out_valid,
  input  logic                         out_ready,
  output logic [FIT_W-1:0]             out_fitness,
  output logic [FIT_W-1:0]             out_weight,
  output logic                         out_feasible,
  output logic [TAG_W-1:0]             out_tag,
  output logic [FIT_W-1:0]             best_fitness,
  output logic [TAG_W-1:0]             best_tag,
  output logic                         best_valid
);

  localparam int unsigned N_CHUNKS = N_ITEMS / LANES;
  localparam int unsigned CNT_W    = (N_CHUNKS > 1) ? $clog2(N_CHUNKS) : 1;
  localparam int unsigned ACC_W    = acc_width(VALUE_W, WEIGHT_W, N_ITEMS);
  localparam int unsigned VSUM_W   = VALUE_W + $clog2(LANES + 1);
  localparam int unsigned WSUM_W   = WEIGHT_W + $clog2(LANES + 1);
  localparam int unsigned MAX_AC   = (ACC_W > CAP_W) ? ACC_W : CAP_W;
  localparam int unsigned MAX_ACF  = (MAX_AC > FIT_W) ? MAX_AC : FIT_W;
  // One spare bit above the shifted penalty guarantees a non-empty saturation slice.
  localparam int unsigned EXT_W    = MAX_ACF + PEN_SHIFT + 1;

  state_e              state;
  logic [CNT_W-1:0]    cnt;
  logic [ACC_W-1:0]    acc_val;
  logic [ACC_W-1:0]    acc_wt;
  logic [N_ITEMS-1:0]  chrom_r;
  logic [TAG_W-1:0]    tag_r;
  logic [CAP_W-1:0]    cap_r;
  mode_e               mode_r;

  int unsigned                chunk_base;
  logic [LANES-1:0]           chunk_sel;
  logic [LANES*VALUE_W-1:0]   chunk_vals;
  logic [LANES*WEIGHT_W-1:0]  chunk_wts;
  logic [VSUM_W-1:0]          chunk_val_sum;
  logic [WSUM_W-1:0]          chunk_wt_sum;

  always_comb begin
    chunk_base = LANES * cnt;
    chunk_sel  = chrom_r[chunk_base +: LANES];
    chunk_vals = item_values[chunk_base*VALUE_W +: LANES*VALUE_W];
    chunk_wts  = item_weights[chunk_base*WEIGHT_W +: LANES*WEIGHT_W];
  end

  ga_chunk_sum #(
    .LANES    (LANES),
    .VALUE_W  (VALUE_W),
    .WEIGHT_W (WEIGHT_W),
    .VSUM_W   (VSUM_W),
    .WSUM_W   (WSUM_W)
  ) u_chunk_sum (
    .sel     (chunk_sel),
    .vals    (chunk_vals),
    .wts     (chunk_wts),
    .val_sum (chunk_val_sum),
    .wt_sum  (chunk_wt_sum)
  );

  logic [EXT_W-1:0] val_x, wt_x, cap_x, excess, penalty, fit_x;
  logic             feasible;
  logic             eligible;
  logic [FIT_W-1:0] fit_sat, wt_sat;

  always_comb begin
    val_x    = EXT_W'(acc_val);
    wt_x     = EXT_W'(acc_wt);
    cap_x    = EXT_W'(cap_r);
    feasible = (wt_x <= cap_x);
    excess   = feasible ? '0 : (wt_x - cap_x);
    penalty  = excess << PEN_SHIFT;
    case (mode_r)
      MODE_PENALTY: fit_x = (val_x > penalty) ? (val_x - penalty) : '0;
      MODE_FREE:    fit_x = val_x;
      default:      fit_x = feasible ? val_x : '0;
    endcase
    fit_sat  = (|fit_x[EXT_W-1:FIT_W]) ? '1 : fit_x[FIT_W-1:0];
    wt_sat   = (|wt_x[EXT_W-1:FIT_W]) ? '1 : wt_x[FIT_W-1:0];
    eligible = feasible || (mode_r == MODE_FREE);
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state        <= ST_IDLE;
      in_ready     <= 1'b0;
      out_valid    <= 1'b0;
      out_fitness  <= '0;
      out_weight   <= '0;
      out_feasible <= 1'b0;
      out_tag      <= '0;
      best_fitness <= '0;
      best_tag     <= '0;
      best_valid   <= 1'b0;
      cnt          <= '0;
      acc_val      <= '0;
      acc_wt       <= '0;
      chrom_r      <= '0;
      tag_r        <= '0;
      cap_r        <= '0;
      mode_r       <= MODE_HARD;
    end else begin
      case (state)
        ST_IDLE: begin
          if (in_valid && in_ready) begin
            chrom_r  <= in_chrom;
            tag_r    <= in_tag;
            cap_r    <= capacity;
            mode_r   <= mode_e'(mode);
            acc_val  <= '0;
            acc_wt   <= '0;
            cnt      <= '0;
            in_ready <= 1'b0;
            state    <= ST_ACCUM;
          end else begin
            in_ready <= 1'b1;
          end
        end
        ST_ACCUM: begin
          acc_val <= acc_val + ACC_W'(chunk_val_sum);
          acc_wt  <= acc_wt + ACC_W'(chunk_wt_sum);
          if (cnt == CNT_W'(N_CHUNKS - 1)) state <= ST_FINAL;
          else                             cnt   <= cnt + 1'b1;
        end
        ST_FINAL: begin
          out_fitness  <= fit_sat;
          out_weight   <= wt_sat;
          out_feasible <= feasible;
          out_tag      <= tag_r;
          out_valid    <= 1'b1;
          state        <= ST_OUT;
        end
        ST_OUT: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            in_ready  <= 1'b1;
            state     <= ST_IDLE;
          end
        end
        default: state <= ST_IDLE;
      endcase

      // A clear coinciding with an eligible result makes that result the first entry.
      if ((state == ST_FINAL) && eligible &&
          (clear_best || !best_valid || (fit_sat > best_fitness))) begin
        best_fitness <= fit_sat;
        best_tag     <= tag_r;
        best_valid   <= 1'b1;
      end else if (clear_best) begin
        best_fitness <= '0;
        best_tag     <= '0;
        best_valid   <= 1'b0;
      end
    end
  end

endmodule
